data_mem_mux: RTL and testbench

DATA_MEM_MUX -- requirements
Module: data_mem_mux

---
 rtl/data_mem_mux.sv | 35 +++
 tb/tb_data_mem_mux.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/data_mem_mux.sv
// Write-back select register: picks the ALU result or memory read data
// and presents it one clock later on out.
module data_mem_mux #(
   parameter int WIDTH = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] aluResult,
   input  logic [WIDTH-1:0] readData,
   input  logic             MemtoReg,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] out_q;

   // Reset wins over the select; both are only seen at the clock edge.
   always_comb begin
      out_d = out_q;
      if (reset) begin
         out_d = '0;
      end else if (MemtoReg) begin
         out_d = readData;
      end else begin
         out_d = aluResult;
      end
   end

   always_ff @(posedge clock) begin
      out_q <= out_d;
   end

   assign out = out_q;

endmodule

// File: tb/tb_data_mem_mux.sv
// Bench for data_mem_mux: reference model plus directed scenarios
// with hand-computed literal expectations.
module tb_data_mem_mux;

   localparam int W = 4;

   logic         clock;
   logic         reset;
   logic [W-1:0] aluResult;
   logic [W-1:0] readData;
   logic         MemtoReg;
   logic [W-1:0] out;

   int vectors;
   int miscompares;

   logic [W-1:0] exp_q;
   bit           model_valid;

   data_mem_mux #(.WIDTH(W)) dut (
      .clock    (clock),
      .reset    (reset),
      .aluResult(aluResult),
      .readData (readData),
      .MemtoReg (MemtoReg),
      .out      (out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [W-1:0] act,
                        input logic [W-1:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   // Reference: the register holds whatever the rules say was chosen at
   // the last rising edge; nothing is known before the first reset edge.
   always @(posedge clock) begin
      if (reset) begin
         exp_q       <= '0;
         model_valid <= 1'b1;
      end else begin
         exp_q <= MemtoReg ? readData : aluResult;
      end
   end

   always @(negedge clock) begin
      if (model_valid) check("model", out, exp_q);
   end

   // Drive at the falling edge, step through one rising edge, settle #1.
   task automatic step(input logic r, input logic [W-1:0] a,
                       input logic [W-1:0] d, input logic s);
      @(negedge clock);
      reset     = r;
      aluResult = a;
      readData  = d;
      MemtoReg  = s;
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic         r;
      logic [W-1:0] a;
      logic [W-1:0] d;
      logic         s;
      logic [W-1:0] e;
   } vec_t;

   vec_t tbl[$];

   initial begin
      vectors     = 0;
      miscompares = 0;
      model_valid = 1'b0;
      reset       = 1'b0;
      aluResult   = '0;
      readData    = '0;
      MemtoReg    = 1'b0;

      step(1'b1, 4'd2, 4'd5, 1'b0);
      check("reset_zero", out, 4'd0);
      step(1'b0, 4'd2, 4'd5, 1'b0);
      check("alu_2", out, 4'd2);
      step(1'b0, 4'd2, 4'd5, 1'b1);
      check("mem_5", out, 4'd5);
      step(1'b0, 4'd3, 4'd6, 1'b0);
      check("alu_3", out, 4'd3);
      step(1'b0, 4'd3, 4'd6, 1'b1);
      check("mem_6", out, 4'd6);
      step(1'b0, 4'd0, 4'd0, 1'b0);
      check("zero", out, 4'd0);
      step(1'b0, 4'd15, 4'd0, 1'b0);
      check("full_15", out, 4'd15);

      step(1'b0, 4'd2, 4'd7, 1'b0);
      check("pre_mid", out, 4'd2);
      aluResult = 4'd9;
      #2;
      check("mid_hold", out, 4'd2);
      readData = 4'd12;
      MemtoReg = 1'b1;
      #1;
      check("mid_hold_sel", out, 4'd2);
      MemtoReg = 1'b0;
      @(posedge clock);
      #1;
      check("mid_after", out, 4'd9);

      step(1'b0, 4'd1, 4'd6, 1'b1);
      check("pre_rst_6", out, 4'd6);
      @(negedge clock);
      reset = 1'b1;
      #1;
      check("rst_sync", out, 4'd6);
      @(posedge clock);
      #1;
      check("rst_mid", out, 4'd0);
      step(1'b0, 4'd1, 4'd5, 1'b1);
      check("rst_release", out, 4'd5);

      tbl.push_back('{1'b0, 4'd10, 4'd5,  1'b1, 4'd5});
      tbl.push_back('{1'b0, 4'd10, 4'd5,  1'b0, 4'd10});
      tbl.push_back('{1'b0, 4'd8,  4'd1,  1'b1, 4'd1});
      tbl.push_back('{1'b0, 4'd8,  4'd1,  1'b0, 4'd8});
      tbl.push_back('{1'b1, 4'd15, 4'd15, 1'b1, 4'd0});
      tbl.push_back('{1'b0, 4'd0,  4'd15, 1'b1, 4'd15});
      tbl.push_back('{1'b0, 4'd12, 4'd3,  1'b0, 4'd12});
      tbl.push_back('{1'b0, 4'd12, 4'd3,  1'b1, 4'd3});
      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].a, tbl[i].d, tbl[i].s);
         check($sformatf("tbl_%0d", i), out, tbl[i].e);
      end

      for (int i = 0; i < 32; i++) begin
         step(1'b0, W'(i), W'(15 - (i % 16)), i[0]);
      end

      @(negedge clock);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
